// File: rtl/lc3_pkg.sv
// Shared LC3 definitions used by the register file and the execute stage.
//   nzp_t     : condition-code register layout {n, z, p}
//   NZP_RESET : condition codes after reset (Z set)
//   nzp_of()  : condition codes produced by a result value
package lc3_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } nzp_t;

    localparam nzp_t NZP_RESET = 3'b010;

    // Widest data path nzp_of() accepts; callers zero-extend into this width.
    localparam int unsigned NZP_MAX_W = 64;

    // data holds a width-bit value zero-extended to NZP_MAX_W bits, so the
    // zero test can run over the full vector. The sign bit is picked with a
    // shifted mask rather than a variable bit select.
    function automatic nzp_t nzp_of(input logic [NZP_MAX_W-1:0] data,
                                    input int unsigned          width);
        nzp_t                 cc;
        logic [NZP_MAX_W-1:0] msb_mask;
        logic                 neg;
        logic                 zero;
        msb_mask = {{(NZP_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
        neg      = |(data & msb_mask);
        zero     = (data == '0);
        cc.n     = neg;
        cc.z     = zero;
        cc.p     = !neg && !zero;
        return cc;
    endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port of regfile_sb.
//   regs    : current register array contents
//   busy    : current scoreboard vector
//   wr_en / wr_sel / wr_data : writeback in flight this cycle (bypass source)
//   rd_sel  : register to read
//   rd_data : selected register, or the in-flight writeback when bypassing
//   rd_busy : registered busy bit of the selected register (never bypassed)
module regfile_sb_rdport #(
    parameter int W      = 16,
    parameter int N      = 8,
    parameter int AW     = $clog2(N),
    parameter int BYPASS = 1
) (
    input  logic [W-1:0]  regs [N],
    input  logic [N-1:0]  busy,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_sel,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_sel,
    output logic [W-1:0]  rd_data,
    output logic          rd_busy
);

    logic [W-1:0] stored_data;
    logic         bypass_hit;

    assign stored_data = regs[rd_sel];

    // With BYPASS=0 the compare folds to constant 0 and only the array mux remains.
    assign bypass_hit = (BYPASS != 0) && wr_en && (wr_sel == rd_sel);

    assign rd_data = bypass_hit ? wr_data : stored_data;

    // A writeback clearing this register only takes effect at the edge, so a
    // consumer keeps stalling for one more cycle.
    assign rd_busy = busy[rd_sel];

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard and LC3 NZP condition codes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_data/wr_cc : writeback port; wr_cc also updates NZP
//   rsv_en/rsv_sel    : decode-stage reservation of a destination register
//   flush             : clears every busy bit (pipeline squash)
//   rd_sel/rd_data    : NRD packed combinational read ports
//   rd_busy           : busy bit of each read port's register
//   busy              : full scoreboard vector
//   nzp               : condition codes {N,Z,P}
// W must be between 2 and 64 (NZP helper width), N a power of two.
module regfile_sb
    import lc3_pkg::*;
#(
    parameter int W      = 16,
    parameter int N      = 8,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_sel,
    input  logic [W-1:0]      wr_data,
    input  logic              wr_cc,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_sel,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_sel,
    output logic [NRD*W-1:0]  rd_data,
    output logic [NRD-1:0]    rd_busy,
    output logic [N-1:0]      busy,
    output logic [2:0]        nzp
);

    logic [W-1:0]           regs_reg [N];
    logic [N-1:0]           busy_reg;
    logic [N-1:0]           busy_next;
    logic [N-1:0]           wr_hit;
    logic [N-1:0]           rsv_hit;
    nzp_t                   nzp_reg;
    logic [NZP_MAX_W-1:0]   wr_data_ext;

    // Per-register decode and scoreboard next state.
    // Priority: flush clears, then a new reservation sets, then writeback clears.
    for (genvar gi = 0; gi < N; gi++) begin : g_reg
        assign wr_hit[gi]    = wr_en  && (wr_sel  == AW'(gi));
        assign rsv_hit[gi]   = rsv_en && (rsv_sel == AW'(gi));
        assign busy_next[gi] = flush       ? 1'b0 :
                               rsv_hit[gi] ? 1'b1 :
                               wr_hit[gi]  ? 1'b0 :
                                             busy_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                if (wr_hit[r]) begin
                    regs_reg[r] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    always_comb begin
        wr_data_ext          = '0;
        wr_data_ext[W-1:0]   = wr_data;
    end

    // wr_cc is meaningful only alongside a real writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_reg <= NZP_RESET;
        end else if (wr_en && wr_cc) begin
            nzp_reg <= nzp_of(wr_data_ext, W);
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        regfile_sb_rdport #(
            .W      (W),
            .N      (N),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .regs    (regs_reg),
            .busy    (busy_reg),
            .wr_en   (wr_en),
            .wr_sel  (wr_sel),
            .wr_data (wr_data),
            .rd_sel  (rd_sel[gi*AW +: AW]),
            .rd_data (rd_data[gi*W +: W]),
            .rd_busy (rd_busy[gi])
        );
    end

    assign busy = busy_reg;
    assign nzp  = nzp_reg;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int S_A_RD   = 0;
    localparam int S_A_RDB  = 1;
    localparam int S_A_BUSY = 2;
    localparam int S_A_NZP  = 3;
    localparam int S_B_RD   = 4;
    localparam int S_B_BUSY = 5;
    localparam int S_C_RD   = 6;
    localparam int S_C_NZP  = 7;

    logic clk;
    logic rst_n;

    // Shared stimulus for the default instance (A) and the BYPASS=0 instance (B)
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        wr_cc;
    logic        rsv_en;
    logic [2:0]  rsv_sel;
    logic        flush;
    logic [5:0]  rd_sel;

    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [7:0]  a_busy;
    logic [2:0]  a_nzp;
    logic [31:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [7:0]  b_busy;
    logic [2:0]  b_nzp;

    // Wide instance (C): W=32, N=16, NRD=3
    logic        c_wr_en;
    logic [3:0]  c_wr_sel;
    logic [31:0] c_wr_data;
    logic        c_wr_cc;
    logic        c_rsv_en;
    logic [3:0]  c_rsv_sel;
    logic        c_flush;
    logic [11:0] c_rd_sel;
    logic [95:0] c_rd_data;
    logic [2:0]  c_rd_busy;
    logic [15:0] c_busy;
    logic [2:0]  c_nzp;

    regfile_sb u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_cc(wr_cc), .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush),
        .rd_sel(rd_sel), .rd_data(a_rd_data), .rd_busy(a_rd_busy), .busy(a_busy), .nzp(a_nzp)
    );

    regfile_sb #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_cc(wr_cc), .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush),
        .rd_sel(rd_sel), .rd_data(b_rd_data), .rd_busy(b_rd_busy), .busy(b_busy), .nzp(b_nzp)
    );

    regfile_sb #(.W(32), .N(16), .NRD(3)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_sel(c_wr_sel), .wr_data(c_wr_data),
        .wr_cc(c_wr_cc), .rsv_en(c_rsv_en), .rsv_sel(c_rsv_sel), .flush(c_flush),
        .rd_sel(c_rd_sel), .rd_data(c_rd_data), .rd_busy(c_rd_busy), .busy(c_busy), .nzp(c_nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sig;
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input int sig, input int port, input logic [63:0] exp,
                              input string name);
        exp_t e;
        e.sig  = sig;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    function automatic logic [63:0] actual(input int sig, input int port);
        case (sig)
            S_A_RD:   return 64'(a_rd_data[port*16 +: 16]);
            S_A_RDB:  return 64'(a_rd_busy[port]);
            S_A_BUSY: return 64'(a_busy);
            S_A_NZP:  return 64'(a_nzp);
            S_B_RD:   return 64'(b_rd_data[port*16 +: 16]);
            S_B_BUSY: return 64'(b_busy);
            S_C_RD:   return 64'(c_rd_data[port*32 +: 32]);
            S_C_NZP:  return 64'(c_nzp);
            default:  return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    // Monitor: compare every expectation queued for this cycle at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e   = q.pop_front();
            act = actual(e.sig, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s port%0d: got %0h required %0h", e.name, e.port, act, e.exp);
            end else begin
                $display("%0t %s port%0d: got %0h ok", $time, e.name, e.port, act);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input int p0, input int p1);
        rd_sel = {3'(p1), 3'(p0)};
    endtask

    task automatic wr(input logic en, input int s, input logic [15:0] d, input logic cc);
        wr_en   = en;
        wr_sel  = 3'(s);
        wr_data = d;
        wr_cc   = cc;
    endtask

    initial begin
        rst_n = 1'b0;
        wr(1'b0, 0, 16'h0, 1'b0);
        rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0; rd_sel = '0;
        c_wr_en = 1'b0; c_wr_sel = '0; c_wr_data = '0; c_wr_cc = 1'b0;
        c_rsv_en = 1'b0; c_rsv_sel = '0; c_flush = 1'b0; c_rd_sel = '0;

        repeat (2) step();
        step();
        expect_val(S_A_RD, 0, 64'h0, "reset_rd");
        expect_val(S_A_RD, 1, 64'h0, "reset_rd");
        expect_val(S_A_BUSY, 0, 64'h00, "reset_busy");
        expect_val(S_A_NZP, 0, 64'h2, "reset_nzp");
        expect_val(S_A_RDB, 0, 64'h0, "reset_rd_busy");
        expect_val(S_C_NZP, 0, 64'h2, "c_reset_nzp");
        expect_val(S_C_RD, 0, 64'h0, "c_reset_rd");

        step();
        rst_n = 1'b1;
        expect_val(S_A_NZP, 0, 64'h2, "release_nzp");
        expect_val(S_A_BUSY, 0, 64'h00, "release_busy");

        // R3 = 1234 with CC; wide instance writes R15 = all ones with CC
        step();
        wr(1'b1, 3, 16'h1234, 1'b1); sel(0, 0);
        expect_val(S_A_RD, 0, 64'h0, "rd_other_reg");
        c_wr_en = 1'b1; c_wr_sel = 4'd15; c_wr_data = 32'hFFFF_FFFF; c_wr_cc = 1'b1;
        c_rd_sel = {4'd15, 4'd15, 4'd15};
        for (int k = 0; k < 3; k++) expect_val(S_C_RD, k, 64'hFFFF_FFFF, "c_bypass");
        expect_val(S_C_NZP, 0, 64'h2, "c_nzp_before_edge");

        step();
        wr(1'b0, 3, 16'h0, 1'b0); sel(3, 0);
        expect_val(S_A_RD, 0, 64'h1234, "rd_r3");
        expect_val(S_B_RD, 0, 64'h1234, "b_rd_r3");
        expect_val(S_A_NZP, 0, 64'h1, "nzp_pos");
        c_wr_en = 1'b0; c_wr_cc = 1'b0;
        for (int k = 0; k < 3; k++) expect_val(S_C_RD, k, 64'hFFFF_FFFF, "c_rd_r15");
        expect_val(S_C_NZP, 0, 64'h4, "c_nzp_neg");

        step();
        wr(1'b1, 5, 16'h8000, 1'b1); sel(3, 5);
        expect_val(S_A_RD, 1, 64'h8000, "bypass_r5");
        expect_val(S_B_RD, 1, 64'h0, "b_nobypass_r5");
        expect_val(S_A_NZP, 0, 64'h1, "nzp_hold_pre_edge");

        step();
        wr(1'b1, 5, 16'h0000, 1'b1);
        expect_val(S_A_NZP, 0, 64'h4, "nzp_neg");
        expect_val(S_A_RD, 1, 64'h0, "bypass_r5_zero");
        expect_val(S_B_RD, 1, 64'h8000, "b_old_r5");

        // wr_cc without wr_en must not touch NZP
        step();
        wr(1'b0, 5, 16'h1234, 1'b1);
        expect_val(S_A_NZP, 0, 64'h2, "nzp_zero");
        expect_val(S_A_RD, 1, 64'h0, "rd_r5_zero");

        step();
        wr(1'b0, 5, 16'h0, 1'b0);
        expect_val(S_A_NZP, 0, 64'h2, "cc_without_en");

        // Both ports select the register being written this cycle
        step();
        wr(1'b1, 2, 16'hBEEF, 1'b0); sel(2, 2);
        expect_val(S_A_RD, 0, 64'hBEEF, "bypass_dual");
        expect_val(S_A_RD, 1, 64'hBEEF, "bypass_dual");
        expect_val(S_B_RD, 0, 64'h0, "b_nobypass_dual");
        expect_val(S_B_RD, 1, 64'h0, "b_nobypass_dual");

        step();
        wr(1'b0, 0, 16'h0, 1'b0);
        rsv_en = 1'b1; rsv_sel = 3'd4; sel(4, 2);
        expect_val(S_A_BUSY, 0, 64'h00, "rsv_pre_edge");
        expect_val(S_A_RDB, 0, 64'h0, "rsv_rd_busy_pre");
        expect_val(S_A_RD, 1, 64'hBEEF, "rd_r2");
        expect_val(S_B_RD, 1, 64'hBEEF, "b_rd_r2");

        step();
        rsv_en = 1'b0;
        expect_val(S_A_BUSY, 0, 64'h10, "rsv_r4");
        expect_val(S_A_RDB, 0, 64'h1, "rd_busy_r4");
        expect_val(S_A_RDB, 1, 64'h0, "rd_busy_r2");

        // Writeback to a reserved register: busy stays visible until the edge
        step();
        wr(1'b1, 4, 16'h0042, 1'b0);
        expect_val(S_A_BUSY, 0, 64'h10, "wb_busy_pre_edge");
        expect_val(S_A_RDB, 0, 64'h1, "wb_rd_busy_not_bypassed");
        expect_val(S_A_RD, 0, 64'h0042, "wb_bypass_r4");
        expect_val(S_B_RD, 0, 64'h0, "b_wb_old_r4");

        step();
        wr(1'b0, 4, 16'h0, 1'b0);
        expect_val(S_A_BUSY, 0, 64'h00, "wb_clears_busy");
        expect_val(S_A_RDB, 0, 64'h0, "wb_clears_rd_busy");
        expect_val(S_B_RD, 0, 64'h0042, "b_rd_r4");

        // Same-cycle reserve and writeback to R4: reservation wins, data lands
        step();
        rsv_en = 1'b1; rsv_sel = 3'd4;
        wr(1'b1, 4, 16'h5555, 1'b0);
        expect_val(S_A_BUSY, 0, 64'h00, "rsv_wb_pre_edge");

        step();
        rsv_en = 1'b0;
        wr(1'b0, 4, 16'h0, 1'b0);
        expect_val(S_A_BUSY, 0, 64'h10, "rsv_beats_wb");
        expect_val(S_B_RD, 0, 64'h5555, "rsv_wb_data");
        expect_val(S_A_RDB, 0, 64'h1, "rsv_beats_wb_rd_busy");

        // Clear R4, reserve R1 then R6
        step();
        rsv_en = 1'b1; rsv_sel = 3'd1;
        wr(1'b1, 4, 16'h5555, 1'b0);
        expect_val(S_A_BUSY, 0, 64'h10, "pre_rsv_r1");

        step();
        rsv_sel = 3'd6;
        wr(1'b0, 4, 16'h0, 1'b0);
        expect_val(S_A_BUSY, 0, 64'h02, "rsv_r1");

        step();
        flush = 1'b1; rsv_sel = 3'd7;
        expect_val(S_A_BUSY, 0, 64'h42, "rsv_r1_r6");

        step();
        flush = 1'b0; rsv_en = 1'b0;
        expect_val(S_A_BUSY, 0, 64'h00, "flush_over_rsv");
        expect_val(S_B_BUSY, 0, 64'h00, "b_flush_over_rsv");

        // Load state, then reset asynchronously in the middle of a cycle
        step();
        wr(1'b1, 3, 16'h7777, 1'b1);
        rsv_en = 1'b1; rsv_sel = 3'd2; sel(3, 2);
        expect_val(S_A_RD, 0, 64'h7777, "pre_reset_bypass");
        expect_val(S_B_RD, 0, 64'h1234, "b_pre_reset_old");
        expect_val(S_A_RD, 1, 64'hBEEF, "pre_reset_r2");

        step();
        rsv_en = 1'b0;
        wr(1'b1, 6, 16'h9999, 1'b1);
        rst_n = 1'b0;
        expect_val(S_A_RD, 0, 64'h0, "async_reset_r3");
        expect_val(S_B_RD, 0, 64'h0, "b_async_reset_r3");
        expect_val(S_A_RD, 1, 64'h0, "async_reset_r2");
        expect_val(S_A_BUSY, 0, 64'h00, "async_reset_busy");
        expect_val(S_A_NZP, 0, 64'h2, "async_reset_nzp");
        expect_val(S_C_NZP, 0, 64'h2, "c_async_reset_nzp");
        expect_val(S_C_RD, 0, 64'h0, "c_async_reset_rd");

        step();
        wr(1'b0, 0, 16'h0, 1'b0);
        rst_n = 1'b1;

        step();
        expect_val(S_A_RD, 0, 64'h0, "post_reset_r3");
        expect_val(S_A_BUSY, 0, 64'h00, "post_reset_busy");
        expect_val(S_A_NZP, 0, 64'h2, "post_reset_nzp");

        step();
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x16 LC3 register file, built for the pipelined core.
- Provides N registers of width W and NRD combinational read ports with optional write-to-read bypass.
- Adds a per-register busy scoreboard: the decode stage reserves a destination, writeback clears it.
- Adds the LC3 NZP condition-code register, updated from writeback data.

Parameters:
- W, 16, data width in bits (min 2).
- N, 8, number of registers (power of two, min 2).
- NRD, 2, number of read ports (min 1).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads show the stored value only.
- AW, $clog2(N), derived select width; not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  writeback strobe.
- wr_sel  in  AW  writeback destination register.
- wr_data  in  W  writeback data.
- wr_cc  in  1  with wr_en, also update NZP from wr_data.
- rsv_en  in  1  reserve destination (mark busy).
- rsv_sel  in  AW  register to reserve.
- flush  in  1  clear all busy bits (pipeline squash).
- rd_sel  in  NRD*AW  packed read selects; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*W  packed read data; port k uses bits [k*W +: W].
- rd_busy  out  NRD  busy bit of the register selected on port k.
- busy  out  N  full scoreboard vector.
- nzp  out  3  condition codes {N,Z,P}.

Behaviour:
- Reset (async assert, sync-safe deassert on clk):
  - all registers = 0
  - busy = 0
  - nzp = 3'b010 (Z)
  - rd_data therefore reads 0 and rd_busy reads 0.
- Write: on clk edge, if wr_en, reg[wr_sel] <= wr_data; array-visible the next cycle.
- Read: rd_data is combinational from rd_sel, zero cycles latency.
  - BYPASS=1: if wr_en && wr_sel == rd_sel[k], port k shows wr_data in the same cycle.
  - BYPASS=0: port k shows the old value until the edge.
- Multiple read ports may select the same register; each port is independent.
- Scoreboard next-state per register r, priority high to low:
  - flush → 0 (flush overrides a simultaneous rsv_en; the reservation is dropped)
  - rsv_en && rsv_sel == r → 1 (a new reservation wins over a same-cycle writeback to r)
  - wr_en && wr_sel == r → 0
  - else hold.
- rd_busy[k] = busy[rd_sel[k]], registered state only; not bypassed. A writeback clearing r still shows busy until the edge.
- NZP: on edge, if wr_en && wr_cc, nzp <= {wr_data[W-1], wr_data == 0, !wr_data[W-1] && wr_data != 0}. Exactly one bit is set at all times.
- wr_cc without wr_en is ignored.
- Reset mid-operation: all state returns to reset values immediately; pending reservations are lost.
- No illegal selects: N is a power of two, so every AW code is valid.

Decomposition:
- Shared package lc3_pkg:
  - NZP_RESET constant (3'b010)
  - nzp_t typedef
  - function nzp_of(data), also used by the CC logic in the execute stage.
- One sub-module, regfile_sb_rdport: one read port, covering mux plus bypass compare plus busy lookup, instantiated NRD times in a generate loop.
- Storage, scoreboard and NZP stay in the top level.

Test Plan:
- Reset: hold rst_n=0 then release → all rd_data=0, busy=8'h00, nzp=3'b010; assert rst_n=0 mid-write → regs clear without waiting for clk.
- Write/read: write R3=16'h1234 (wr_cc=1); next cycle rd_sel0=3 → 16'h1234, nzp=3'b001; write R5=16'h8000 (wr_cc=1) → nzp=3'b100; write R5=0 (wr_cc=1) → nzp=3'b010.
- Bypass: BYPASS=1, wr_en, wr_sel=2, wr_data=16'hBEEF, rd_sel0=rd_sel1=2 in the same cycle → both ports 16'hBEEF that cycle; BYPASS=0 → both show the old value (0).
- Scoreboard: rsv R4 → busy=8'h10, rd_busy=1 on a port selecting 4; writeback R4 → busy=0 next cycle; same-cycle rsv R4 + wr R4 → busy[4] stays 1 and R4 holds the new data.
- Flush: reserve R1, R6 → busy=8'h42; flush with simultaneous rsv R7 → busy=8'h00.
- Parametric: W=32, N=16, NRD=3; write R15=32'hFFFF_FFFF (wr_cc=1) → all three ports selecting 15 read it, nzp=3'b100.
